// File: rtl/i2c_reg_ctrl_pkg.sv
// Shared FSM encoding and read/write flag constants for the I2C register-bank sequencer.
package i2c_reg_ctrl_pkg;

   typedef enum logic [3:0] {
      IDLE    = 4'b0001,
      GET_PTR = 4'b0010,
      RECV    = 4'b0100,
      SEND    = 4'b1000
   } state_t;

   localparam logic RW_SLAVE_RECV = 1'b1;
   localparam logic RW_SLAVE_SEND = 1'b0;

endpackage

// File: rtl/i2c_reg_bank.sv
// REG_COUNT x 8 register storage with an I2C write port that takes priority over the host write port.
module i2c_reg_bank
   import i2c_reg_ctrl_pkg::*;
#(
   parameter int         REG_COUNT   = 16,
   parameter logic [7:0] RESET_VALUE = 8'h00,
   parameter int         PTR_W       = $clog2(REG_COUNT)
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             i2c_wr_en,
   input  logic [PTR_W-1:0] i2c_wr_addr,
   input  logic [7:0]       i2c_wr_data,
   input  logic             host_wr_en,
   input  logic [PTR_W-1:0] host_wr_addr,
   input  logic [7:0]       host_wr_data,
   input  logic [PTR_W-1:0] host_rd_addr,
   output logic [7:0]       host_rd_data,
   input  logic [PTR_W-1:0] ptr_addr,
   output logic [7:0]       ptr_data
);

   logic [7:0] mem [REG_COUNT];

   // The I2C assignment comes last so it overrides a host write to the same register.
   always_ff @(posedge clock) begin
      if (reset) begin
         for (int i = 0; i < REG_COUNT; i++) begin
            mem[i] <= RESET_VALUE;
         end
      end else begin
         if (host_wr_en) begin
            mem[host_wr_addr] <= host_wr_data;
         end
         if (i2c_wr_en) begin
            mem[i2c_wr_addr] <= i2c_wr_data;
         end
      end
   end

   assign host_rd_data = mem[host_rd_addr];
   assign ptr_data     = mem[ptr_addr];

endmodule

// File: rtl/i2c_slave_reg_ctrl.sv
// I2C register-bank sequencer: first inbound byte sets the pointer, later bytes write/read with auto-increment.
// Optional write protection enabled by defining I2C_REG_CTRL_WRITE_PROTECT_EN.
module i2c_slave_reg_ctrl
   import i2c_reg_ctrl_pkg::*;
#(
   parameter int         REG_COUNT   = 16,
   parameter logic [7:0] RESET_VALUE = 8'h00,
   localparam int        PTR_W       = $clog2(REG_COUNT)
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             enable,
   output logic             slv_enable,
   input  logic [7:0]       slv_data_read,
   output logic [7:0]       slv_data_write,
   input  logic             slv_read_write_flag,
   input  logic             slv_data_finish,
   input  logic             slv_transfer_status,
   input  logic             slv_error,
   input  logic [PTR_W-1:0] host_rd_addr,
   output logic [7:0]       host_rd_data,
   input  logic             host_wr_en,
   input  logic [PTR_W-1:0] host_wr_addr,
   input  logic [7:0]       host_wr_data,
`ifdef I2C_REG_CTRL_WRITE_PROTECT_EN
   input  logic [REG_COUNT-1:0] wp_mask,
   output logic             wp_violation,
`endif
   output logic             reg_written,
   output logic [PTR_W-1:0] reg_written_addr,
   output logic [PTR_W-1:0] reg_ptr,
   output logic             ptr_error
);

   localparam logic [8:0] COUNT9 = 9'(REG_COUNT);

   state_t     state;
   logic       status_d;
   logic       xfer_start;
   logic       xfer_end;
   logic       rx_byte_ok;
   logic       i2c_wr_en;
   logic [7:0] ptr_data;

   assign xfer_start = slv_transfer_status & ~status_d;
   assign xfer_end   = ~slv_transfer_status & status_d;
   assign rx_byte_ok = (state == RECV) && slv_data_finish && !slv_error;

`ifdef I2C_REG_CTRL_WRITE_PROTECT_EN
   logic wp_hit;
   assign wp_hit    = wp_mask[reg_ptr];
   assign i2c_wr_en = rx_byte_ok && !wp_hit;
`else
   assign i2c_wr_en = rx_byte_ok;
`endif

   i2c_reg_bank #(
      .REG_COUNT   (REG_COUNT),
      .RESET_VALUE (RESET_VALUE),
      .PTR_W       (PTR_W)
   ) u_bank (
      .clock        (clock),
      .reset        (reset),
      .i2c_wr_en    (i2c_wr_en),
      .i2c_wr_addr  (reg_ptr),
      .i2c_wr_data  (slv_data_read),
      .host_wr_en   (host_wr_en),
      .host_wr_addr (host_wr_addr),
      .host_wr_data (host_wr_data),
      .host_rd_addr (host_rd_addr),
      .host_rd_data (host_rd_data),
      .ptr_addr     (reg_ptr),
      .ptr_data     (ptr_data)
   );

   // A byte finishing together with the transfer end is still processed before returning to IDLE.
   always_ff @(posedge clock) begin
      if (reset) begin
         state            <= IDLE;
         status_d         <= 1'b0;
         slv_enable       <= 1'b0;
         slv_data_write   <= RESET_VALUE;
         reg_ptr          <= '0;
         reg_written      <= 1'b0;
         reg_written_addr <= '0;
         ptr_error        <= 1'b0;
`ifdef I2C_REG_CTRL_WRITE_PROTECT_EN
         wp_violation     <= 1'b0;
`endif
      end else begin
         status_d       <= slv_transfer_status;
         slv_enable     <= enable;
         slv_data_write <= ptr_data;
         reg_written    <= i2c_wr_en;
         if (i2c_wr_en) begin
            reg_written_addr <= reg_ptr;
         end
         case (state)
            IDLE: begin
               if (xfer_start) begin
                  ptr_error <= 1'b0;
`ifdef I2C_REG_CTRL_WRITE_PROTECT_EN
                  wp_violation <= 1'b0;
`endif
                  state <= (slv_read_write_flag == RW_SLAVE_RECV) ? GET_PTR : SEND;
               end
            end
            GET_PTR: begin
               if (slv_data_finish) begin
                  reg_ptr <= slv_data_read[PTR_W-1:0];
                  if ({1'b0, slv_data_read} >= COUNT9) begin
                     ptr_error <= 1'b1;
                  end
                  state <= RECV;
               end
               if (xfer_end) begin
                  state <= IDLE;
               end
            end
            RECV: begin
               // Protected registers still advance the pointer so the stream stays aligned.
               if (rx_byte_ok) begin
                  reg_ptr <= reg_ptr + 1'b1;
`ifdef I2C_REG_CTRL_WRITE_PROTECT_EN
                  if (wp_hit) begin
                     wp_violation <= 1'b1;
                  end
`endif
               end
               if (xfer_end) begin
                  state <= IDLE;
               end
            end
            SEND: begin
               if (slv_data_finish) begin
                  reg_ptr <= reg_ptr + 1'b1;
               end
               if (xfer_end) begin
                  state <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_i2c_slave_reg_ctrl.sv
// Scoreboard testbench for i2c_slave_reg_ctrl; optional write-protect checks follow I2C_REG_CTRL_WRITE_PROTECT_EN.
module tb_i2c_slave_reg_ctrl;
   import i2c_reg_ctrl_pkg::*;

   localparam int N = 16;

   logic       clock = 1'b0;
   logic       reset = 1'b0;
   logic       enable = 1'b1;
   logic       slv_enable;
   logic [7:0] slv_data_read = 8'h00;
   logic [7:0] slv_data_write;
   logic       slv_read_write_flag = 1'b0;
   logic       slv_data_finish = 1'b0;
   logic       slv_transfer_status = 1'b0;
   logic       slv_error = 1'b0;
   logic [3:0] host_rd_addr = 4'h0;
   logic [7:0] host_rd_data;
   logic       host_wr_en = 1'b0;
   logic [3:0] host_wr_addr = 4'h0;
   logic [7:0] host_wr_data = 8'h00;
   logic       reg_written;
   logic [3:0] reg_written_addr;
   logic [3:0] reg_ptr;
   logic       ptr_error;
   logic [15:0] wp_mask = 16'h0000;
`ifdef I2C_REG_CTRL_WRITE_PROTECT_EN
   logic       wp_violation;
`endif

   int compared = 0;
   int mismatched = 0;

   logic [7:0] model [N];
   logic [3:0] mptr;
   logic       mptr_err;
   logic       mwp;
   logic       rx_first;
   logic [3:0] wr_q [$];
   logic [7:0] rd_q [$];
   logic [3:0] mon_exp;
   logic [7:0] rd_exp;

   i2c_slave_reg_ctrl #(.REG_COUNT(N), .RESET_VALUE(8'h00)) dut (
      .clock               (clock),
      .reset               (reset),
      .enable              (enable),
      .slv_enable          (slv_enable),
      .slv_data_read       (slv_data_read),
      .slv_data_write      (slv_data_write),
      .slv_read_write_flag (slv_read_write_flag),
      .slv_data_finish     (slv_data_finish),
      .slv_transfer_status (slv_transfer_status),
      .slv_error           (slv_error),
      .host_rd_addr        (host_rd_addr),
      .host_rd_data        (host_rd_data),
      .host_wr_en          (host_wr_en),
      .host_wr_addr        (host_wr_addr),
      .host_wr_data        (host_wr_data),
`ifdef I2C_REG_CTRL_WRITE_PROTECT_EN
      .wp_mask             (wp_mask),
      .wp_violation        (wp_violation),
`endif
      .reg_written         (reg_written),
      .reg_written_addr    (reg_written_addr),
      .reg_ptr             (reg_ptr),
      .ptr_error           (ptr_error)
   );

   always #5 clock = ~clock;

   // Every reg_written pulse must match the next address the model queued.
   always @(posedge clock) begin
      #1;
      if (reg_written === 1'b1) begin
         compared++;
         if (wr_q.size() == 0) begin
            mismatched++;
            $display("[TB] FAIL reg_written_unexpected: got pulse addr=%0h, required no pulse", reg_written_addr);
         end else begin
            mon_exp = wr_q.pop_front();
            if (reg_written_addr !== mon_exp) begin
               mismatched++;
               $display("[TB] FAIL reg_written_addr: got %0h, required %0h", reg_written_addr, mon_exp);
            end
         end
      end
   end

   initial begin
      #500000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog");
   end

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic begin_xfer(input logic rw);
      slv_read_write_flag = rw;
      slv_transfer_status = 1'b1;
      rx_first = 1'b1;
      mptr_err = 1'b0;
      mwp = 1'b0;
      tick();
      tick();
   endtask

   task automatic end_xfer();
      slv_transfer_status = 1'b0;
      tick();
      tick();
   endtask

   task automatic rx_byte(input logic [7:0] d, input logic err, input logic hw,
                          input logic [3:0] ha, input logic [7:0] hd, input logic last);
      if (hw) model[ha] = hd;
      if (rx_first) begin
         mptr = d[3:0];
         if (d >= 8'(N)) mptr_err = 1'b1;
         rx_first = 1'b0;
      end else if (!err) begin
         if (wp_mask[mptr]) begin
            mwp = 1'b1;
         end else begin
            model[mptr] = d;
            wr_q.push_back(mptr);
         end
         mptr = mptr + 4'd1;
      end
      slv_data_read = d;
      slv_error = err;
      slv_data_finish = 1'b1;
      host_wr_en = hw;
      host_wr_addr = ha;
      host_wr_data = hd;
      if (last) slv_transfer_status = 1'b0;
      tick();
      slv_data_finish = 1'b0;
      slv_error = 1'b0;
      host_wr_en = 1'b0;
   endtask

   task automatic host_write(input logic [3:0] a, input logic [7:0] d);
      host_wr_en = 1'b1;
      host_wr_addr = a;
      host_wr_data = d;
      model[a] = d;
      tick();
      host_wr_en = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      tick();
      tick();
      compared++;
      if ({slv_enable, reg_written, ptr_error} !== 3'b000) begin
         mismatched++;
         $display("[TB] FAIL reset_flags: got %b, required 000", {slv_enable, reg_written, ptr_error});
      end
      compared++;
      if (reg_ptr !== 4'h0 || slv_data_write !== 8'h00) begin
         mismatched++;
         $display("[TB] FAIL reset_ptr_data: got ptr=%0h write=%0h, required 0/00", reg_ptr, slv_data_write);
      end
      reset = 1'b0;
      for (int i = 0; i < N; i++) model[i] = 8'h00;
      mptr = 4'h0;
      mptr_err = 1'b0;
      mwp = 1'b0;
      tick();
      for (int i = 0; i < N; i++) begin
         host_rd_addr = 4'(i);
         #1;
         compared++;
         if (host_rd_data !== 8'h00) begin
            mismatched++;
            $display("[TB] FAIL reset_bank[%0d]: got %0h, required 00", i, host_rd_data);
         end
      end
   endtask

   task automatic test_enable();
      enable = 1'b0;
      tick();
      compared++;
      if (slv_enable !== 1'b0) begin
         mismatched++;
         $display("[TB] FAIL enable_low: got %b, required 0", slv_enable);
      end
      enable = 1'b1;
      tick();
      compared++;
      if (slv_enable !== 1'b1) begin
         mismatched++;
         $display("[TB] FAIL enable_high: got %b, required 1", slv_enable);
      end
   endtask

   task automatic test_recv();
      begin_xfer(RW_SLAVE_RECV);
      rx_byte(8'h03, 1'b0, 1'b0, 4'h0, 8'h00, 1'b0);
      rx_byte(8'hA5, 1'b0, 1'b0, 4'h0, 8'h00, 1'b0);
      rx_byte(8'h5A, 1'b0, 1'b0, 4'h0, 8'h00, 1'b0);
      end_xfer();
      for (int i = 3; i <= 4; i++) begin
         host_rd_addr = 4'(i);
         #1;
         compared++;
         if (host_rd_data !== model[i]) begin
            mismatched++;
            $display("[TB] FAIL recv_bank[%0d]: got %0h, required %0h", i, host_rd_data, model[i]);
         end
      end
      compared++;
      if (reg_ptr !== mptr) begin
         mismatched++;
         $display("[TB] FAIL recv_ptr: got %0h, required %0h", reg_ptr, mptr);
      end
   endtask

   task automatic test_repeated_start();
      host_write(4'h2, 8'h11);
      begin_xfer(RW_SLAVE_RECV);
      rx_byte(8'h02, 1'b0, 1'b0, 4'h0, 8'h00, 1'b0);
      end_xfer();
      begin_xfer(RW_SLAVE_SEND);
      for (int k = 0; k < 3; k++) begin
         rd_q.push_back(model[mptr]);
         mptr = mptr + 4'd1;
      end
      for (int k = 0; k < 3; k++) begin
         rd_exp = rd_q.pop_front();
         compared++;
         if (slv_data_write !== rd_exp) begin
            mismatched++;
            $display("[TB] FAIL send_byte[%0d]: got %0h, required %0h", k, slv_data_write, rd_exp);
         end
         slv_data_finish = 1'b1;
         tick();
         slv_data_finish = 1'b0;
         tick();
      end
      end_xfer();
      compared++;
      if (reg_ptr !== mptr) begin
         mismatched++;
         $display("[TB] FAIL send_ptr: got %0h, required %0h", reg_ptr, mptr);
      end
   endtask

   task automatic test_wrap_and_ptr_error();
      begin_xfer(RW_SLAVE_RECV);
      rx_byte(8'h0F, 1'b0, 1'b0, 4'h0, 8'h00, 1'b0);
      rx_byte(8'h77, 1'b0, 1'b0, 4'h0, 8'h00, 1'b0);
      rx_byte(8'h88, 1'b0, 1'b0, 4'h0, 8'h00, 1'b0);
      end_xfer();
      host_rd_addr = 4'hF;
      #1;
      compared++;
      if (host_rd_data !== 8'h77) begin
         mismatched++;
         $display("[TB] FAIL wrap_bank15: got %0h, required 77", host_rd_data);
      end
      host_rd_addr = 4'h0;
      #1;
      compared++;
      if (host_rd_data !== 8'h88) begin
         mismatched++;
         $display("[TB] FAIL wrap_bank0: got %0h, required 88", host_rd_data);
      end
      begin_xfer(RW_SLAVE_RECV);
      rx_byte(8'h20, 1'b0, 1'b0, 4'h0, 8'h00, 1'b0);
      end_xfer();
      compared++;
      if (ptr_error !== mptr_err || reg_ptr !== mptr) begin
         mismatched++;
         $display("[TB] FAIL ptr_error: got err=%b ptr=%0h, required err=%b ptr=%0h", ptr_error, reg_ptr, mptr_err, mptr);
      end
   endtask

   task automatic test_slv_error();
      begin_xfer(RW_SLAVE_RECV);
      compared++;
      if (ptr_error !== 1'b0) begin
         mismatched++;
         $display("[TB] FAIL ptr_error_clear: got %b, required 0", ptr_error);
      end
      rx_byte(8'h08, 1'b0, 1'b0, 4'h0, 8'h00, 1'b0);
      rx_byte(8'hAB, 1'b1, 1'b0, 4'h0, 8'h00, 1'b0);
      rx_byte(8'hCD, 1'b0, 1'b0, 4'h0, 8'h00, 1'b0);
      end_xfer();
      host_rd_addr = 4'h8;
      #1;
      compared++;
      if (host_rd_data !== 8'hCD || reg_ptr !== 4'h9) begin
         mismatched++;
         $display("[TB] FAIL slv_error_drop: got bank8=%0h ptr=%0h, required CD/9", host_rd_data, reg_ptr);
      end
   endtask

   task automatic test_host_collision();
      begin_xfer(RW_SLAVE_RECV);
      rx_byte(8'h06, 1'b0, 1'b0, 4'h0, 8'h00, 1'b0);
      rx_byte(8'h44, 1'b0, 1'b1, 4'h6, 8'hCC, 1'b0);
      end_xfer();
      host_rd_addr = 4'h6;
      #1;
      compared++;
      if (host_rd_data !== 8'h44) begin
         mismatched++;
         $display("[TB] FAIL collision_same: got %0h, required 44", host_rd_data);
      end
      begin_xfer(RW_SLAVE_RECV);
      rx_byte(8'h06, 1'b0, 1'b0, 4'h0, 8'h00, 1'b0);
      rx_byte(8'h44, 1'b0, 1'b1, 4'h7, 8'hBB, 1'b0);
      end_xfer();
      host_rd_addr = 4'h7;
      #1;
      compared++;
      if (host_rd_data !== 8'hBB) begin
         mismatched++;
         $display("[TB] FAIL collision_other: got %0h, required BB", host_rd_data);
      end
   endtask

   task automatic test_end_with_finish();
      begin_xfer(RW_SLAVE_RECV);
      rx_byte(8'h09, 1'b0, 1'b0, 4'h0, 8'h00, 1'b0);
      rx_byte(8'h3C, 1'b0, 1'b0, 4'h0, 8'h00, 1'b1);
      tick();
      host_rd_addr = 4'h9;
      #1;
      compared++;
      if (host_rd_data !== 8'h3C || reg_ptr !== mptr) begin
         mismatched++;
         $display("[TB] FAIL end_with_finish: got bank9=%0h ptr=%0h, required 3C/%0h", host_rd_data, reg_ptr, mptr);
      end
   endtask

`ifdef I2C_REG_CTRL_WRITE_PROTECT_EN
   task automatic test_write_protect();
      wp_mask = 16'h0010;
      begin_xfer(RW_SLAVE_RECV);
      rx_byte(8'h04, 1'b0, 1'b0, 4'h0, 8'h00, 1'b0);
      rx_byte(8'hEE, 1'b0, 1'b0, 4'h0, 8'h00, 1'b0);
      end_xfer();
      host_rd_addr = 4'h4;
      #1;
      compared++;
      if (host_rd_data !== 8'h5A || reg_ptr !== 4'h5) begin
         mismatched++;
         $display("[TB] FAIL wp_drop: got bank4=%0h ptr=%0h, required 5A/5", host_rd_data, reg_ptr);
      end
      compared++;
      if (wp_violation !== mwp) begin
         mismatched++;
         $display("[TB] FAIL wp_violation: got %b, required %b", wp_violation, mwp);
      end
      wp_mask = 16'h0000;
   endtask
`endif

   task automatic test_final_bank();
      compared++;
      if (wr_q.size() != 0) begin
         mismatched++;
         $display("[TB] FAIL missing_reg_written: got %0d pulses outstanding, required 0", wr_q.size());
      end
      for (int i = 0; i < N; i++) begin
         host_rd_addr = 4'(i);
         #1;
         compared++;
         if (host_rd_data !== model[i]) begin
            mismatched++;
            $display("[TB] FAIL final_bank[%0d]: got %0h, required %0h", i, host_rd_data, model[i]);
         end
      end
   endtask

   initial begin
      test_reset();
      test_enable();
      test_recv();
      test_repeated_start();
      test_wrap_and_ptr_error();
      test_slv_error();
      test_host_collision();
      test_end_with_finish();
`ifdef I2C_REG_CTRL_WRITE_PROTECT_EN
      test_write_protect();
`endif
      tick();
      test_final_bank();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
